// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, FSM state encoding and default divider widths
package alu_pkg;
    localparam logic [1:0] OP_DIV = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;
    localparam int DEF_WIDTH_N = 6;
    localparam int DEF_WIDTH_D = 3;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/divider_alu_if.sv
// divider_alu_if: divider request/result bus
// master drives en/op/start/Dividend/Divisor; slave returns Quot/Rem/busy/done/div_by_zero
interface divider_alu_if
    import alu_pkg::*;
#(
    parameter int WIDTH_N = DEF_WIDTH_N,
    parameter int WIDTH_D = DEF_WIDTH_D
);
    logic               en;
    logic [1:0]         op;
    logic               start;
    logic [WIDTH_N-1:0] Dividend;
    logic [WIDTH_D-1:0] Divisor;
    logic [WIDTH_N-1:0] Quot;
    logic [WIDTH_D-1:0] Rem;
    logic               busy;
    logic               done;
    logic               div_by_zero;
    modport master (
        output en, op, start, Dividend, Divisor,
        input  Quot, Rem, busy, done, div_by_zero
    );
    modport slave (
        input  en, op, start, Dividend, Divisor,
        output Quot, Rem, busy, done, div_by_zero
    );
endinterface

// File: rtl/alu_div_step.sv
// alu_div_step: one combinational restoring division step
// i_rem: shifted partial remainder, i_div: divisor, o_rem: next remainder, o_qbit: quotient bit
module alu_div_step
    import alu_pkg::*;
#(
    parameter int WIDTH_D = DEF_WIDTH_D
) (
    input  logic [WIDTH_D:0]   i_rem,
    input  logic [WIDTH_D-1:0] i_div,
    output logic [WIDTH_D:0]   o_rem,
    output logic               o_qbit
);
    assign o_qbit = i_rem >= {1'b0, i_div};
    assign o_rem  = o_qbit ? i_rem - {1'b0, i_div} : i_rem;
endmodule

// File: rtl/divider_alu.sv
// divider_alu: multi-cycle unsigned restoring divider for the ALU
// clk: clock, rst_n: async active-low reset, bus: divider_alu_if slave (request in, registered result out)
module divider_alu
    import alu_pkg::*;
#(
    parameter int WIDTH_N = DEF_WIDTH_N,
    parameter int WIDTH_D = DEF_WIDTH_D
) (
    input  logic        clk,
    input  logic        rst_n,
    divider_alu_if.slave bus
);
    localparam int CW = $clog2(WIDTH_N + 1);
    state_t             r_state, w_state_n;
    logic [WIDTH_N-1:0] r_dvd, r_quot;
    logic [WIDTH_D-1:0] r_div, r_rem;
    logic [WIDTH_D:0]   r_pr, w_shift, w_pr_n;
    logic [CW-1:0]      r_cnt;
    logic               r_busy, r_done, r_dbz;
    logic               w_qbit, w_accept, w_last, w_busy_n, w_done_n;

    // r_dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom
    assign w_shift  = (r_pr << 1) | (WIDTH_D+1)'(r_dvd[WIDTH_N-1]);
    assign w_accept = bus.en && r_state == ST_IDLE && bus.start && bus.op == OP_DIV;
    // a zero divisor finishes on the first RUN edge without stepping
    assign w_last   = r_div == '0 || r_cnt == CW'(1);

    alu_div_step #(.WIDTH_D(WIDTH_D)) u_step (
        .i_rem  (w_shift),
        .i_div  (r_div),
        .o_rem  (w_pr_n),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        if (bus.en)
            case (r_state)
                ST_IDLE: w_state_n = w_accept ? ST_RUN : ST_IDLE;
                ST_RUN:  w_state_n = w_last ? ST_DONE : ST_RUN;
                default: w_state_n = ST_IDLE;
            endcase
    end

    always_comb begin
        w_busy_n = w_state_n != ST_IDLE;
        w_done_n = w_state_n == ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_div  <= '0;
            r_pr   <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_n;
            r_done <= w_done_n;
            if (w_accept) begin
                r_dvd <= bus.Dividend;
                r_div <= bus.Divisor;
                r_pr  <= '0;
                r_cnt <= CW'(WIDTH_N);
            end else if (bus.en && r_state == ST_RUN) begin
                r_dvd <= {r_dvd[WIDTH_N-2:0], w_qbit};
                r_pr  <= w_pr_n;
                r_cnt <= r_cnt - CW'(1);
                if (w_last) begin
                    r_quot <= r_div == '0 ? '1 : {r_dvd[WIDTH_N-2:0], w_qbit};
                    r_rem  <= r_div == '0 ? '0 : w_pr_n[WIDTH_D-1:0];
                    r_dbz  <= r_div == '0;
                end
            end
        end
    end

    assign bus.Quot        = r_quot;
    assign bus.Rem         = r_rem;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: doc/divider_alu.md
DIVIDER_ALU -- requirements
Module: divider_alu

Interface
REQ-001 SHALL have parameter WIDTH_N, default 6, the dividend and quotient width (matches the ALU product width).
REQ-002 SHALL have parameter WIDTH_D, default 3, the divisor and remainder width (matches the ALU operand width).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  ALU enable; low stalls all state (no advance, no accept).
REQ-006 SHALL have port op  input  2  ALU function select; divide is OP_DIV = 2'b10.
REQ-007 SHALL have port start  input  1  request; sampled only in IDLE with en=1 and op=OP_DIV.
REQ-008 SHALL have port Dividend  input  WIDTH_N  unsigned dividend.
REQ-009 SHALL have port Divisor  input  WIDTH_D  unsigned divisor.
REQ-010 SHALL have port Quot  output  WIDTH_N  registered quotient.
REQ-011 SHALL have port Rem  output  WIDTH_D  registered remainder.
REQ-012 SHALL have port busy  output  1  high in RUN and DONE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port div_by_zero  output  1  registered flag for the last result; valid while done is high and held afterwards.

Function
REQ-015 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE, advancing only on edges where en=1.
REQ-016 SHALL accept a request on an edge where state=IDLE, en=1, op=OP_DIV and start=1, capturing Dividend and Divisor at that edge.
REQ-017 SHALL ignore start, op, Dividend and Divisor while busy=1.
REQ-018 SHALL perform one unsigned restoring shift-subtract step per enabled RUN edge, WIDTH_N steps in total, MSB of the dividend first.
REQ-019 SHALL use a WIDTH_D+1-bit partial remainder and a down-counter of ceil(log2(WIDTH_N+1)) bits.
REQ-020 SHALL set the quotient bit to 1 and keep the difference when partial remainder >= divisor, and otherwise set the bit to 0 and restore the partial remainder.
REQ-021 SHALL, with the request accepted at edge t and en held high, load Quot and Rem at edge t+WIDTH_N and enter DONE at that edge.
REQ-022 SHALL drive done=1 for exactly the cycle spent in DONE, then return to IDLE on the next enabled edge.
REQ-023 SHALL keep Quot, Rem and div_by_zero unchanged from completion until the next completion or reset.
REQ-024 SHALL, when the captured Divisor=0, skip RUN, go to DONE at edge t+1 and load Quot=all-ones, Rem=0 and div_by_zero=1.
REQ-025 SHALL clear div_by_zero on every nonzero-divisor completion.
REQ-026 SHALL, when en is low for k cycles during RUN or DONE, delay completion by exactly k cycles, with done held high while stalled in DONE.
REQ-027 SHALL guarantee Quot*Divisor+Rem == Dividend and Rem < Divisor for every nonzero divisor.
REQ-028 SHALL not accept a new request on the edge that leaves DONE; the minimum request spacing is WIDTH_N+2 cycles.

Reset
REQ-029 SHALL, while rst_n is low, immediately force state=IDLE and Quot, Rem, busy, done, div_by_zero, the counter and all working registers to 0, independent of clk and en.
REQ-030 SHALL abort any operation in progress on reset, producing no done pulse and no partial result.
REQ-031 SHALL accept a request on the first enabled edge after rst_n deasserts.

Structure
REQ-032 SHALL take OP_DIV (2'b10), OP_MUL (2'b11), the state encoding and the default widths from shared package alu_pkg.
REQ-033 SHALL place the single restoring step (partial remainder and divisor in; next remainder and quotient bit out) in combinational sub-module alu_div_step.
REQ-034 SHALL use a 120-400 line RTL implementation, with all outputs driven directly from registers.

Verification
REQ-035 SHALL cover: Dividend=42, Divisor=5, start at edge t -> done high in cycle t+6, Quot=8, Rem=2, div_by_zero=0.
REQ-036 SHALL cover: 63/1 -> Quot=63, Rem=0; 5/7 -> Quot=0, Rem=5; 49/7 -> Quot=7, Rem=0.
REQ-037 SHALL cover: 17/0 -> done at t+1, Quot=63, Rem=0, div_by_zero=1; a following 9/2 -> Quot=4, Rem=1, div_by_zero=0.
REQ-038 SHALL cover: 42/5 with en dropped for 2 cycles mid-RUN -> done at t+8, same result; start pulses while busy have no effect.
REQ-039 SHALL cover: rst_n pulsed low at t+3 -> outputs 0 asynchronously, no done pulse; then 30/4 -> Quot=7, Rem=2.
REQ-040 SHALL cover: exhaustive sweep of all 64x8 operand pairs, checked against REQ-027 and REQ-024, including op!=OP_DIV requests never being accepted.
